// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: parses SYNC/addr/count/data/checksum frames from a byte stream
// and commits only checksum-clean frames as a burst of configuration writes.
`default_nettype none

module cfg_frame_loader #(
  parameter int          ADDR_W = 6,
  parameter int          DATA_W = 5,
  parameter int          DEPTH  = 16,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              enAddress,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] setData,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [1:0]        err_code
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_COUNT  = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [7:0]        count;
  logic [7:0]        idx;
  logic [7:0]        sum;
  logic [DATA_W-1:0] frame_buf [DEPTH];

  logic       take;
  logic [7:0] sum_next;

  assign take     = in_valid & in_ready;
  assign sum_next = sum + in_data;
  assign busy     = (state != S_IDLE);

  // Frame storage carries no reset: it is always fully rewritten before a commit reads it.
  always_ff @(posedge clock) begin
    if (take && state == S_DATA) begin
      frame_buf[idx[IDX_W-1:0]] <= in_data[DATA_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      base      <= '0;
      count     <= '0;
      idx       <= '0;
      sum       <= '0;
      in_ready  <= 1'b0;
      enAddress <= 1'b0;
      address   <= '0;
      setData   <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      enAddress <= 1'b0;
      in_ready  <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take && in_data == SYNC) begin
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (take) begin
            if ((in_data >> ADDR_W) != 8'd0) begin
              cfg_err  <= 1'b1;
              err_code <= 2'd1;
              state    <= S_IDLE;
            end else begin
              base  <= ADDR_W'(in_data);
              sum   <= in_data;
              state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (take) begin
            if (in_data == 8'd0 || {1'b0, in_data} > DEPTH_L) begin
              cfg_err  <= 1'b1;
              err_code <= 2'd2;
              state    <= S_IDLE;
            end else begin
              count <= in_data;
              sum   <= sum_next;
              idx   <= 8'd0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            sum <= sum_next;
            idx <= idx + 8'd1;
            if (idx == count - 8'd1) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (take) begin
            if (sum_next != 8'd0) begin
              cfg_err  <= 1'b1;
              err_code <= 2'd3;
              state    <= S_IDLE;
            end else begin
              // First write is issued straight from the accepting edge.
              state     <= S_COMMIT;
              in_ready  <= 1'b0;
              enAddress <= 1'b1;
              address   <= base;
              setData   <= frame_buf[IDX_W'(0)];
              idx       <= 8'd1;
            end
          end
        end
        S_COMMIT: begin
          if (idx == count) begin
            cfg_done <= 1'b1;
            state    <= S_IDLE;
          end else begin
            in_ready  <= 1'b0;
            enAddress <= 1'b1;
            address   <= base + ADDR_W'(idx);
            setData   <= frame_buf[idx[IDX_W-1:0]];
            idx       <= idx + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
